// File: rtl/if_inst_rdata_buffer_pkg.sv
// if_inst_rdata_buffer_pkg: shared fetch-packet width and outstanding-request limit
package if_inst_rdata_buffer_pkg;
  localparam int INST_PACKET_W = 64;
  localparam int MAX_OUTST = 2;
  localparam int CNT_WIDTH = 2;
  typedef logic [INST_PACKET_W-1:0] inst_pkt_t;
endpackage

// File: rtl/if_req_tracker.sv
// if_req_tracker: counts outstanding fetches and filters responses cancelled by a flush
module if_req_tracker
  import if_inst_rdata_buffer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTST,
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             addr_ok_i,
  input  logic             data_ok_i,
  input  logic             flush_i,
  output logic             data_ok_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic [CNT_W-1:0] discard_o
);
  logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic accept, discard_now;
  always_comb begin
    accept = req_i & addr_ok_i;
    discard_now = data_ok_i & ((discard_q != '0) | flush_i);
    data_ok_o = data_ok_i & ~discard_now;
    outstanding_d = (accept & ~data_ok_i) ? outstanding_q + CNT_W'(1) :
                    (~accept & data_ok_i) ? outstanding_q - CNT_W'(1) : outstanding_q;
    // the response returning in the flush cycle is dropped directly, so it is not counted
    discard_d = flush_i ? outstanding_q - CNT_W'(data_ok_i) :
                (data_ok_i & (discard_q != '0)) ? discard_q - CNT_W'(1) : discard_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      discard_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
    end
  end
  assign outstanding_o = outstanding_q;
  assign discard_o = discard_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(accept && !data_ok_i && outstanding_q == CNT_W'(MAX_OUTSTANDING)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(data_ok_i && !accept && outstanding_q == '0));
  a_in_range: assert property (@(posedge clk) disable iff (rst)
    outstanding_q <= CNT_W'(MAX_OUTSTANDING));
endmodule

// File: rtl/if_inst_rdata_buffer.sv
// if_inst_rdata_buffer: filters fetch responses and holds one packet while ID stalls
module if_inst_rdata_buffer
  import if_inst_rdata_buffer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTST,
  parameter int CNT_W = CNT_WIDTH,
  parameter int DATA_W = INST_PACKET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_req_i,
  input  logic              inst_sram_addr_ok_i,
  input  logic              inst_sram_data_ok_i,
  input  logic [DATA_W-1:0] inst_sram_rdata_i,
  input  logic              if_valid_i,
  input  logic              id_allowin_i,
  input  logic              excep_flush_i,
  output logic              data_ok_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              inst_rdata_buffer_ok_o,
  output logic [DATA_W-1:0] inst_rdata_buffer_rdata_o,
  output logic              req_block_o
);
  logic [CNT_W-1:0] outstanding, discard;
  logic buf_ok_q, buf_ok_d, buf_set;
  logic [DATA_W-1:0] buf_rdata_q, buf_rdata_d;
  if_req_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_tracker (
    .clk(clk),
    .rst(rst),
    .req_i(inst_sram_req_i),
    .addr_ok_i(inst_sram_addr_ok_i),
    .data_ok_i(inst_sram_data_ok_i),
    .flush_i(excep_flush_i),
    .data_ok_o(data_ok_o),
    .outstanding_o(outstanding),
    .discard_o(discard)
  );
  always_comb begin
    // an occupied buffer is never overwritten; a second unconsumed packet is illegal
    buf_set = data_ok_o & if_valid_i & ~id_allowin_i & ~excep_flush_i & ~buf_ok_q;
    buf_ok_d = excep_flush_i ? 1'b0 : buf_set ? 1'b1 : (if_valid_i & id_allowin_i) ? 1'b0 : buf_ok_q;
    buf_rdata_d = buf_set ? inst_sram_rdata_i : buf_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_ok_q <= 1'b0;
      buf_rdata_q <= '0;
    end else begin
      buf_ok_q <= buf_ok_d;
      buf_rdata_q <= buf_rdata_d;
    end
  end
  assign rdata_o = inst_sram_rdata_i;
  assign inst_rdata_buffer_ok_o = buf_ok_q;
  assign inst_rdata_buffer_rdata_o = buf_rdata_q;
  assign req_block_o = (outstanding == CNT_W'(MAX_OUTSTANDING)) | buf_ok_q;
  a_no_buf_overrun: assert property (@(posedge clk) disable iff (rst)
    !(data_ok_o && buf_ok_q && !(if_valid_i && id_allowin_i)));
endmodule

// File: tb/tb_if_inst_rdata_buffer.sv
// tb_if_inst_rdata_buffer: directed table, async-reset sequence and randomized model check
module tb_if_inst_rdata_buffer;
  import if_inst_rdata_buffer_pkg::*;
  localparam int MAX = MAX_OUTST;
  localparam logic [63:0] PA = 64'h0000_0013_0280_0000;
  localparam logic [63:0] PB = 64'hdead_beef_1234_5678;
  localparam logic [63:0] PC = 64'h0bad_f00d_cafe_babe;
  logic clk = 1'b0;
  logic rst, req, aok, dok, iv, al, fl;
  logic [63:0] rdata;
  logic dok_o, bok_o, blk_o;
  logic [63:0] rdata_o, bdata_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  if_inst_rdata_buffer dut (
    .clk(clk),
    .rst(rst),
    .inst_sram_req_i(req),
    .inst_sram_addr_ok_i(aok),
    .inst_sram_data_ok_i(dok),
    .inst_sram_rdata_i(rdata),
    .if_valid_i(iv),
    .id_allowin_i(al),
    .excep_flush_i(fl),
    .data_ok_o(dok_o),
    .rdata_o(rdata_o),
    .inst_rdata_buffer_ok_o(bok_o),
    .inst_rdata_buffer_rdata_o(bdata_o),
    .req_block_o(blk_o)
  );
  typedef struct {
    logic req, aok, dok;
    logic [63:0] rdata;
    logic iv, al, fl;
    logic e_dok, e_bok, e_blk;
    logic [63:0] e_bdata;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, a, d, input logic [63:0] rd, input logic v, w, f);
    req = r; aok = a; dok = d; rdata = rd; iv = v; al = w; fl = f;
  endtask
  function automatic vec_t mk(input logic r, a, d, input logic [63:0] rd, input logic v, w, f,
                              input logic ed, eb, ek, input logic [63:0] bd);
    vec_t x;
    x.req = r; x.aok = a; x.dok = d; x.rdata = rd; x.iv = v; x.al = w; x.fl = f;
    x.e_dok = ed; x.e_bok = eb; x.e_blk = ek; x.e_bdata = bd;
    return x;
  endfunction
  // reference model: in-order queue of outstanding requests, each tagged stale or live
  bit q[$];
  logic m_bok;
  logic [63:0] m_bdata;
  initial begin
    drive(0, 0, 0, 64'h0, 0, 0, 0);
    rst = 1'b1;
    #12;
    chk("reset_data_ok", dok_o, 0);
    chk("reset_buf_ok", bok_o, 0);
    chk("reset_buf_rdata", bdata_o, 0);
    chk("reset_req_block", blk_o, 0);
    rst = 1'b0;
    // single fetch, ID ready
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, PA, 1, 1, 0, 1, 0, 0, 0));
    // ID stall then release
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, PA, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 1, PA));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 1, PA));
    vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 1, 1, PA));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // flush with two outstanding, then a post-flush request
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, PB, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, PB, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, PB, 1, 1, 0, 1, 0, 0, 0));
    // flush coinciding with data_ok at two outstanding
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, PB, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, PC, 1, 1, 0, 0, 0, 0, 0));
    // flush while the buffer is full
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, PB, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 1, PB));
    vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].aok, vecs[i].dok, vecs[i].rdata, vecs[i].iv, vecs[i].al, vecs[i].fl);
      #2;
      chk($sformatf("v%0d_data_ok", i), dok_o, vecs[i].e_dok);
      chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rdata);
      chk($sformatf("v%0d_buf_ok", i), bok_o, vecs[i].e_bok);
      chk($sformatf("v%0d_req_block", i), blk_o, vecs[i].e_blk);
      if (vecs[i].e_bok) chk($sformatf("v%0d_buf_rdata", i), bdata_o, vecs[i].e_bdata);
      @(posedge clk);
      #1;
    end
    // async reset in the middle of a stall with one request outstanding
    drive(1, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 1, 1, PC, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("stall_buf_ok", bok_o, 1);
    chk("stall_buf_rdata", bdata_o, PC);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_buf_ok", bok_o, 0);
    chk("arst_buf_rdata", bdata_o, 0);
    chk("arst_req_block", blk_o, 0);
    chk("arst_data_ok", dok_o, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // randomized run against the queue model
    q.delete();
    m_bok = 1'b0;
    m_bdata = '0;
    for (int n = 0; n < 3000; n++) begin
      logic f, d, v, w, r, a, disc, e_dok;
      logic [63:0] rd;
      f = ($urandom_range(15) == 0);
      d = (q.size() > 0) && ($urandom_range(2) == 0);
      v = ($urandom_range(3) != 0);
      w = $urandom_range(1);
      disc = d && (f || q[0]);
      if (d && !disc && m_bok && !(v && w)) d = 1'b0;
      disc = d && (f || q[0]);
      r = $urandom_range(1);
      a = $urandom_range(1);
      if (r && a && !d && q.size() == MAX) a = 1'b0;
      rd = {$urandom, $urandom};
      drive(r, a, d, rd, v, w, f);
      e_dok = d && !disc;
      #2;
      chk("rnd_data_ok", dok_o, e_dok);
      chk("rnd_rdata", rdata_o, rd);
      chk("rnd_buf_ok", bok_o, m_bok);
      chk("rnd_buf_rdata", bdata_o, m_bdata);
      chk("rnd_req_block", blk_o, (q.size() == MAX) || m_bok);
      if (f) m_bok = 1'b0;
      else if (e_dok && v && !w && !m_bok) begin
        m_bok = 1'b1;
        m_bdata = rd;
      end else if (v && w) m_bok = 1'b0;
      if (d) void'(q.pop_front());
      if (f) foreach (q[k]) q[k] = 1'b1;
      if (r && a) q.push_back(1'b0);
      @(posedge clk);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
